// File: rtl/rpn_pkg.sv
// Shared opcodes, FSM states and operand width for the RPN division path.
package rpn_pkg;

    localparam int unsigned WIDTH = 8;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MOD   = 3'b011;
    localparam logic [2:0] OP_DROP  = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    typedef enum logic [0:0] {IDLE, EXEC} state_e;

endpackage

// File: rtl/rpn_div_sequencer_if.sv
// Command handshake between the board front end and the RPN sequencer.
interface rpn_div_sequencer_if;

    logic                     cmd_valid;
    logic [2:0]               cmd_op;
    logic [rpn_pkg::WIDTH-1:0] din;
    logic                     cmd_ready;
    logic                     done;

    modport master (
        output cmd_valid, cmd_op, din,
        input  cmd_ready, done
    );

    modport slave (
        input  cmd_valid, cmd_op, din,
        output cmd_ready, done
    );

endinterface

// File: rtl/rpn_stack_regs.sv
// Operand register file: one write port, read ports for top and next entries.
module rpn_stack_regs
    import rpn_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    top_addr,
    input  logic [AW-1:0]    next_addr,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] next_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are don't-care beyond count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign top_data  = mem_q[top_addr];
    assign next_data = mem_q[next_addr];

endmodule

// File: rtl/rpn_div_sequencer.sv
// Operand stack and command sequencer feeding an external combinational 8x8 divider.
module rpn_div_sequencer
    import rpn_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    rpn_div_sequencer_if.slave       cmd,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    input  logic [WIDTH-1:0]         div_q,
    input  logic [WIDTH-1:0]         div_r,
    input  logic                     div_e,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_div0,
    output logic                     err_under,
    output logic                     err_over
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
    logic             is_mod_q, is_mod_d;
    logic             done_q, done_d;
    logic             err_div0_q, err_div0_d, err_under_q, err_under_d, err_over_q, err_over_d;

    logic             accept, is_divop;
    logic             we;
    logic [AW-1:0]    waddr, top_addr, next_addr;
    logic [WIDTH-1:0] wdata, top_data, next_data;

    assign accept    = cmd.cmd_valid && cmd.cmd_ready;
    assign is_divop  = (cmd.cmd_op == OP_DIV) || (cmd.cmd_op == OP_MOD);
    assign top_addr  = count_q[AW-1:0] - AW'(1);
    assign next_addr = count_q[AW-1:0] - AW'(2);

    rpn_stack_regs #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .top_addr  (top_addr),
        .next_addr (next_addr),
        .top_data  (top_data),
        .next_data (next_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_divop && count_q >= CW'(2)) state_d = EXEC;
            EXEC: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state_q == IDLE);
        cmd.done      = done_q;
    end

    always_comb begin
        count_d     = count_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        is_mod_d    = is_mod_q;
        done_d      = 1'b0;
        err_div0_d  = err_div0_q;
        err_under_d = err_under_q;
        err_over_d  = err_over_q;
        we          = 1'b0;
        waddr       = count_q[AW-1:0];
        wdata       = cmd.din;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (cmd.cmd_op)
                        OP_PUSH: begin
                            if (count_q < DEPTH_C) begin
                                we      = 1'b1;
                                count_d = count_q + CW'(1);
                            end else begin
                                err_over_d = 1'b1;
                            end
                        end
                        OP_DROP: begin
                            if (count_q != '0) count_d = count_q - CW'(1);
                            else               err_under_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            count_d     = '0;
                            err_div0_d  = 1'b0;
                            err_under_d = 1'b0;
                            err_over_d  = 1'b0;
                        end
                        OP_DIV, OP_MOD: begin
                            if (count_q < CW'(2)) begin
                                err_under_d = 1'b1;
                            end else begin
                                div_a_d  = next_data;
                                div_b_d  = top_data;
                                is_mod_d = (cmd.cmd_op == OP_MOD);
                                done_d   = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                done_d = 1'b1;
                if (div_e) begin
                    err_div0_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    waddr   = next_addr;
                    wdata   = is_mod_q ? div_r : div_q;
                    count_d = count_q - CW'(1);
                end
            end
            default: ;
        endcase
        // A reset landing on EXEC must not commit the pending result.
        if (rst) we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            is_mod_q    <= 1'b0;
            done_q      <= 1'b0;
            err_div0_q  <= 1'b0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            is_mod_q    <= is_mod_d;
            done_q      <= done_d;
            err_div0_q  <= err_div0_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
        end
    end

    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign count     = count_q;
    assign top       = (count_q == '0) ? '0 : top_data;
    assign err_div0  = err_div0_q;
    assign err_under = err_under_q;
    assign err_over  = err_over_q;

endmodule

// File: tb/tb_rpn_div_sequencer.sv
// Directed, table-driven bench for rpn_div_sequencer with a behavioural divider beside it.
module tb_rpn_div_sequencer;
    import rpn_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] div_a, div_b, div_q, div_r, top;
    logic       div_e;
    logic [2:0] count;
    logic       err_div0, err_under, err_over;

    int passed = 0;
    int total  = 0;

    rpn_div_sequencer_if bus ();

    rpn_div_sequencer #(
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (bus),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_e     (div_e),
        .top       (top),
        .count     (count),
        .err_div0  (err_div0),
        .err_under (err_under),
        .err_over  (err_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (div_b == 8'd0) begin
            div_e = 1'b1;
            div_q = 8'hFF;
            div_r = div_a;
        end else begin
            div_e = 1'b0;
            div_q = div_a / div_b;
            div_r = div_a % div_b;
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        logic       exp_exec;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_top;
        logic [2:0] exp_cnt;
        logic [2:0] exp_err;   // {div0, under, over}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add(input logic [2:0] op, input logic [7:0] d, input logic ex,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] t,
                       input logic [2:0] c, input logic [2:0] e);
        vec_t v;
        v.op = op; v.d = d; v.exp_exec = ex; v.exp_a = a; v.exp_b = b;
        v.exp_top = t; v.exp_cnt = c; v.exp_err = e;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.din       = v.d;
        check({tag, "_ready_before"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'(!v.exp_exec));
        if (v.exp_exec) begin
            check({tag, "_div_a"}, 32'(div_a), 32'(v.exp_a));
            check({tag, "_div_b"}, 32'(div_b), 32'(v.exp_b));
            check({tag, "_done_early"}, 32'(bus.done), 32'd0);
            n = 0;
            while (!bus.cmd_ready && n < 8) begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_top"}, 32'(top), 32'(v.exp_top));
        check({tag, "_count"}, 32'(count), 32'(v.exp_cnt));
        check({tag, "_errs"}, 32'({err_div0, err_under, err_over}), 32'(v.exp_err));
        check({tag, "_done"}, 32'(bus.done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //   op        din  exec a    b   top cnt err
        add(OP_PUSH,  100, 0,   0,   0, 100, 1, 3'b000);
        add(OP_PUSH,    7, 0,   0,   0,   7, 2, 3'b000);
        add(OP_DIV,     0, 1, 100,   7,  14, 1, 3'b000);
        add(OP_CLEAR,   0, 0,   0,   0,   0, 0, 3'b000);
        add(OP_PUSH,  100, 0,   0,   0, 100, 1, 3'b000);
        add(OP_PUSH,    7, 0,   0,   0,   7, 2, 3'b000);
        add(OP_MOD,     0, 1, 100,   7,   2, 1, 3'b000);
        add(OP_PUSH,    3, 0,   0,   0,   3, 2, 3'b000);
        add(OP_DIV,     0, 1,   2,   3,   0, 1, 3'b000);
        add(OP_CLEAR,   0, 0,   0,   0,   0, 0, 3'b000);
        add(OP_PUSH,    9, 0,   0,   0,   9, 1, 3'b000);
        add(OP_PUSH,    0, 0,   0,   0,   0, 2, 3'b000);
        add(OP_DIV,     0, 1,   9,   0,   0, 2, 3'b100);
        add(OP_DROP,    0, 0,   0,   0,   9, 1, 3'b100);
        add(OP_CLEAR,   0, 0,   0,   0,   0, 0, 3'b000);
        add(OP_PUSH,    1, 0,   0,   0,   1, 1, 3'b000);
        add(OP_PUSH,    2, 0,   0,   0,   2, 2, 3'b000);
        add(OP_PUSH,    3, 0,   0,   0,   3, 3, 3'b000);
        add(OP_PUSH,    4, 0,   0,   0,   4, 4, 3'b000);
        add(OP_PUSH,    5, 0,   0,   0,   4, 4, 3'b001);
        add(OP_DROP,    0, 0,   0,   0,   3, 3, 3'b001);
        add(OP_CLEAR,   0, 0,   0,   0,   0, 0, 3'b000);
        add(OP_PUSH,    5, 0,   0,   0,   5, 1, 3'b000);
        add(OP_DIV,     0, 0,   0,   0,   5, 1, 3'b010);
        add(OP_CLEAR,   0, 0,   0,   0,   0, 0, 3'b000);
        add(OP_DROP,    0, 0,   0,   0,   0, 0, 3'b010);
        add(OP_NOP,     0, 0,   0,   0,   0, 0, 3'b010);
        add(3'b111,    77, 0,   0,   0,   0, 0, 3'b010);
        add(OP_MOD,     0, 0,   0,   0,   0, 0, 3'b010);
        add(OP_CLEAR,   0, 0,   0,   0,   0, 0, 3'b000);

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.din       = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_top", 32'(top), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_div_a", 32'(div_a), 32'd0);
        check("reset_div_b", 32'(div_b), 32'd0);
        check("reset_errs", 32'({err_div0, err_under, err_over}), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back pushes with cmd_valid held across two edges.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_PUSH;
        bus.din       = 8'd50;
        @(posedge clk);
        #1 bus.din = 8'd60;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_count", 32'(count), 32'd2);
        check("b2b_top", 32'(top), 32'd60);
        check("b2b_done", 32'(bus.done), 32'd1);
        v = '{OP_DIV, 8'd0, 1'b1, 8'd50, 8'd60, 8'd0, 3'd1, 3'b000};
        run_vec(v, "b2b_div");
        @(negedge clk);
        check("div_done_single", 32'(bus.done), 32'd0);

        // Reset landing on the EXEC cycle discards the pending result.
        v = '{OP_CLEAR, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 3'd0, 3'b000};
        run_vec(v, "rx_clear");
        v = '{OP_PUSH, 8'd200, 1'b0, 8'd0, 8'd0, 8'd200, 3'd1, 3'b000};
        run_vec(v, "rx_push200");
        v = '{OP_PUSH, 8'd10, 1'b0, 8'd0, 8'd0, 8'd10, 3'd2, 3'b000};
        run_vec(v, "rx_push10");
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DIV;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("rx_exec_ready", 32'(bus.cmd_ready), 32'd0);
        check("rx_div_a", 32'(div_a), 32'd200);
        check("rx_div_b", 32'(div_b), 32'd10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rx_count", 32'(count), 32'd0);
        check("rx_top", 32'(top), 32'd0);
        check("rx_ready", 32'(bus.cmd_ready), 32'd1);
        check("rx_done", 32'(bus.done), 32'd0);
        check("rx_div_a_cleared", 32'(div_a), 32'd0);
        @(negedge clk);
        check("rx_done_later", 32'(bus.done), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rpn_div_sequencer.md
# rpn_div_sequencer

Operand stack and command sequencer for the RPN ALU division path. Holds up to DEPTH 8-bit operands entered from the board. On DIV or MOD it pops the two top entries, presents them to the combinational 8x8 divider and pushes the divider's quotient or remainder back. Sits directly upstream of the divider: it drives the dividend and divisor, and consumes the quotient, remainder and divide-by-zero flag.

## Interface
- DEPTH, 4, stack entries (power of two, ≥2)
- WIDTH, 8, operand width (fixed 8 for the divider)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_op  in  3  opcode: 000 NOP, 001 PUSH, 010 DIV, 011 MOD, 100 DROP, 101 CLEAR, 11x NOP
- din  in  WIDTH  operand for PUSH
- cmd_ready  out  1  sequencer can accept a command
- div_a  out  WIDTH  registered dividend to divider
- div_b  out  WIDTH  registered divisor to divider
- div_q  in  WIDTH  divider quotient (combinational from div_a/div_b)
- div_r  in  WIDTH  divider remainder
- div_e  in  1  divider divide-by-zero flag
- top  out  WIDTH  top-of-stack; 0 when empty
- count  out  log2(DEPTH)+1  number of valid entries
- err_div0, err_under, err_over  out  1 each  sticky error flags
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, EXEC. A command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready = (state == IDLE).
- PUSH: if count < DEPTH, write din at the top and increment count. Otherwise leave the stack unchanged and set err_over.
- DROP: if count ≥ 1, decrement count. Otherwise set err_under.
- CLEAR: count ← 0 and all error flags ← 0. Stack contents need not be zeroed.
- NOP and reserved opcodes: no state change. done still pulses.
- DIV/MOD with count < 2: set err_under, leave the stack unchanged, stay in IDLE.
- DIV/MOD with count ≥ 2:
  - Load div_a ← entry[count-2] (next) and div_b ← entry[count-1] (top).
  - Latch the op into a register. Go to EXEC.
- EXEC, one cycle, always returns to IDLE:
  - If div_e = 1: set err_div0 and leave the stack unchanged (operands kept).
  - Otherwise: count ← count-1 and entry[count-2] ← div_q for DIV, or div_r for MOD.
- Error flags are sticky. Only CLEAR or rst clears them. Errors never block later commands.
- Arithmetic is unsigned 8-bit. No width extension. The result always fits.

## Timing
- Reset values: cmd_ready=1, div_a=0, div_b=0, top=0, count=0, all error flags=0, done=0, state IDLE.
- PUSH/DROP/CLEAR/NOP accepted at edge k:
  - Updated top and count are visible after edge k.
  - done=1 during the cycle after edge k.
  - cmd_ready stays 1, so back-to-back commands are allowed every cycle.
- DIV/MOD accepted at edge k:
  - div_a and div_b are valid after edge k. cmd_ready=0 for one cycle.
  - The divider result is sampled at edge k+1. The stack and flags update at edge k+1.
  - done=1 during the cycle after edge k+1. cmd_ready returns to 1 after edge k+1.
  - Throughput: one division per 2 cycles.
- div_a and div_b hold their last values outside EXEC.
- The divider path is one full clock period of combinational logic. No multicycle constraint is applied.
- rst asserted during EXEC: the pending result is discarded. After the edge, the stack is empty and the block is in IDLE with cmd_ready=1.
- cmd_valid while cmd_ready=0 is ignored, not queued. The source must hold it.

## Structure
- Package rpn_pkg holds:
  - opcode localparams OP_NOP, OP_PUSH, OP_DIV, OP_MOD, OP_DROP, OP_CLEAR
  - the state enum {IDLE, EXEC}
  - WIDTH
- Sub-module rpn_stack_regs holds the DEPTH×WIDTH register file, with one write port, a read port for top, and a read port for next. The top level keeps the FSM, count, error flags and divider registers.
- The divider is instantiated beside this block in the ALU top, not inside it.

## Test plan
- PUSH 100, PUSH 7, DIV → div_a=100, div_b=7 after accept. After EXEC: top=14, count=1, done pulses once, no error flags.
- PUSH 100, PUSH 7, MOD → top=2, count=1. Then PUSH 3, DIV → top=0, count=1.
- PUSH 9, PUSH 0, DIV → err_div0=1, count=2, top=0, next entry still 9. CLEAR → err_div0=0, count=0.
- DEPTH+1 pushes of 1,2,3,4,5 → count=4, top=4, err_over=1. The fifth push does not modify the stack.
- Single PUSH 5, DIV → err_under=1, count=1, top=5, cmd_ready never drops.
- PUSH 200, PUSH 10, DIV, rst asserted on the EXEC cycle → count=0, top=0, cmd_ready=1, no done pulse.
